// File: rtl/ladybird_mem_arbiter.sv
// ladybird_mem_arbiter
// Shares a single memory port between the core's instruction-fetch (I) and
// data (D) requesters. Round-robin selection with a hold ("lock") while the
// memory stalls a presented request, in-order responses routed back through
// a small ID FIFO, and at most MAX_OUTSTANDING requests in flight.
// Optional build macro LADYBIRD_ARB_PERF_EN adds three 32-bit performance
// counters (perf_i_grants, perf_d_grants, perf_stall_cycles).

`timescale 1ns/1ps

module ladybird_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch requester
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    output logic                  i_resp_valid,
    output logic [DATA_W-1:0]     i_resp_data,
    // data requester
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_W-1:0]     d_req_wdata,
    input  logic [DATA_W/8-1:0]   d_req_wstrb,
    output logic                  d_resp_valid,
    output logic [DATA_W-1:0]     d_resp_data,
    // memory port
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [ADDR_W-1:0]     m_req_addr,
    output logic                  m_req_we,
    output logic [DATA_W-1:0]     m_req_wdata,
    output logic [DATA_W/8-1:0]   m_req_wstrb,
    input  logic                  m_resp_valid,
    input  logic [DATA_W-1:0]     m_resp_data
`ifdef LADYBIRD_ARB_PERF_EN
    ,
    output logic [31:0]           perf_i_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // OPEN: free to pick a requester; LOCKED: a presented request was
    // refused by memory, so the same requester stays selected.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    req_id_e                r_lock_id;
    req_id_e                r_rr;
    req_id_e                w_sel;

    req_id_e                r_fifo_id [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_sel_valid;
    logic                   w_m_valid;
    logic                   w_accept;
    logic                   w_pop;
    req_id_e                w_head_id;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Pick the requester presented to memory this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_sel = REQ_I;
        if (r_state == ST_LOCKED) begin
            w_sel = r_lock_id;
        end else if (i_req_valid && !d_req_valid) begin
            w_sel = REQ_I;
        end else if (d_req_valid && !i_req_valid) begin
            w_sel = REQ_D;
        end else if (i_req_valid && d_req_valid) begin
            w_sel = r_rr;
        end
    end

    assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty     = (r_count == '0);
    assign w_sel_valid = (w_sel == REQ_D) ? d_req_valid : i_req_valid;

    // Reset gates the handshake outputs directly so they read 0 from the
    // very first reset cycle, before any state has been cleared.
    assign w_m_valid = !reset && w_sel_valid && !w_full;
    assign w_accept  = w_m_valid && m_req_ready;

    // A response with nothing outstanding is stale (e.g. pre-reset) and dropped.
    assign w_pop     = !reset && m_resp_valid && !w_empty;
    assign w_head_id = r_fifo_id[r_rd_ptr];

    assign m_req_valid = w_m_valid;
    assign i_req_ready = w_accept && (w_sel == REQ_I);
    assign d_req_ready = w_accept && (w_sel == REQ_D);

    // Forward the selected requester's payload; I fetches are plain reads.
    always_comb begin
        m_req_addr  = i_req_addr;
        m_req_we    = 1'b0;
        m_req_wdata = '0;
        m_req_wstrb = '0;
        if (w_sel == REQ_D) begin
            m_req_addr  = d_req_addr;
            m_req_we    = d_req_we;
            m_req_wdata = d_req_wdata;
            m_req_wstrb = d_req_wstrb;
        end
    end

    // Route the memory response to whoever issued the oldest outstanding request.
    assign i_resp_valid = w_pop && (w_head_id == REQ_I);
    assign d_resp_valid = w_pop && (w_head_id == REQ_D);
    assign i_resp_data  = m_resp_data;
    assign d_resp_data  = m_resp_data;

    // Lock state transitions: hold the selection across a memory stall.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OPEN: begin
                if (w_m_valid && !m_req_ready) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    w_state_next = ST_OPEN;
                end
            end
            default: w_state_next = ST_OPEN;
        endcase
    end

    // Arbitration state: lock, locked requester and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state   <= ST_OPEN;
            r_lock_id <= REQ_I;
            r_rr      <= REQ_I;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_OPEN && w_state_next == ST_LOCKED) begin
                r_lock_id <= w_sel;
            end
            if (w_accept) begin
                r_rr <= (w_sel == REQ_I) ? REQ_D : REQ_I;
            end
        end
    end

    // ID FIFO control: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID FIFO storage: record which requester each accepted request belongs to.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count/pointers define which entries are live.
        if (w_accept) begin
            r_fifo_id[r_wr_ptr] <= w_sel;
        end
    end

`ifdef LADYBIRD_ARB_PERF_EN
    logic [31:0] r_perf_i;
    logic [31:0] r_perf_d;
    logic [31:0] r_perf_stall;

    // Performance counters: grants per side and cycles with demand but no grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_i     <= '0;
            r_perf_d     <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept && w_sel == REQ_I) begin
                r_perf_i <= r_perf_i + 32'd1;
            end
            if (w_accept && w_sel == REQ_D) begin
                r_perf_d <= r_perf_d + 32'd1;
            end
            if ((i_req_valid || d_req_valid) && !w_accept) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_i_grants     = r_perf_i;
    assign perf_d_grants     = r_perf_d;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_ladybird_mem_arbiter.sv
// tb_ladybird_mem_arbiter
// Self-checking bench: directed scenarios (reset, contention, lock, full,
// store) followed by a long randomized run. A transaction-level model
// (queue of in-flight requests, remembered favoured/held side) predicts
// every output each cycle; a small in-order memory model drives responses.

`timescale 1ns/1ps

module tb_ladybird_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                i_req_valid;
    logic                i_req_ready;
    logic [ADDR_W-1:0]   i_req_addr;
    logic                i_resp_valid;
    logic [DATA_W-1:0]   i_resp_data;
    logic                d_req_valid;
    logic                d_req_ready;
    logic [ADDR_W-1:0]   d_req_addr;
    logic                d_req_we;
    logic [DATA_W-1:0]   d_req_wdata;
    logic [STRB_W-1:0]   d_req_wstrb;
    logic                d_resp_valid;
    logic [DATA_W-1:0]   d_resp_data;
    logic                m_req_valid;
    logic                m_req_ready;
    logic [ADDR_W-1:0]   m_req_addr;
    logic                m_req_we;
    logic [DATA_W-1:0]   m_req_wdata;
    logic [STRB_W-1:0]   m_req_wstrb;
    logic                m_resp_valid;
    logic [DATA_W-1:0]   m_resp_data;
`ifdef LADYBIRD_ARB_PERF_EN
    logic [31:0]         perf_i_grants;
    logic [31:0]         perf_d_grants;
    logic [31:0]         perf_stall_cycles;
`endif

    ladybird_mem_arbiter #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_we     (d_req_we),
        .d_req_wdata  (d_req_wdata),
        .d_req_wstrb  (d_req_wstrb),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_addr   (m_req_addr),
        .m_req_we     (m_req_we),
        .m_req_wdata  (m_req_wdata),
        .m_req_wstrb  (m_req_wstrb),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data)
`ifdef LADYBIRD_ARB_PERF_EN
        ,
        .perf_i_grants     (perf_i_grants),
        .perf_d_grants     (perf_d_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit side;   // 0 = I, 1 = D
        bit we;
    } flight_t;

    flight_t     inflight[$];     // accepted, not yet answered, oldest first
    bit          held;            // last presented request was refused by memory
    bit          held_side;
    bit          fav_side;        // side that wins when both ask
    int unsigned perf_i, perf_d, perf_stall;
    bit          grant_log[$];
    bit          last_i_acc, last_d_acc;

    // ---------------- memory model ----------------
    typedef struct {
        int unsigned        due;
        logic [DATA_W-1:0]  data;
    } mem_entry_t;

    mem_entry_t  mem_q[$];
    int          mem_budget  = -1;   // -1 unlimited, else responses still allowed
    int          mem_lat_min = 1;
    int          mem_lat_max = 1;
    bit          spurious_en = 0;
    int unsigned cyc = 0;

    // snapshot of DUT outputs at the last checked sample point
    logic              snap_m_valid, snap_m_we, snap_i_ready, snap_d_ready;
    logic              snap_i_resp, snap_d_resp;
    logic [ADDR_W-1:0] snap_m_addr;
    logic [DATA_W-1:0] snap_m_wdata;
    logic [STRB_W-1:0] snap_m_wstrb;

    task automatic drive_mem();
        m_resp_valid = 1'b0;
        m_resp_data  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && mem_budget != 0) begin
            m_resp_valid = 1'b1;
            m_resp_data  = mem_q[0].data;
        end else if (mem_q.size() == 0 && spurious_en && $urandom_range(0, 9) == 0) begin
            m_resp_valid = 1'b1;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance model at the rising edge.
    task automatic step();
        bit      sel, sel_valid, full, exp_mvalid, exp_acc, exp_pop;
        flight_t head;
        head = '0;
        @(negedge clk);
        full = (inflight.size() >= MAX_OUT);
        if (held)                            sel = held_side;
        else if (i_req_valid && d_req_valid) sel = fav_side;
        else                                 sel = d_req_valid;
        sel_valid  = sel ? d_req_valid : i_req_valid;
        exp_mvalid = !reset && sel_valid && !full;
        exp_acc    = exp_mvalid && m_req_ready;
        exp_pop    = !reset && m_resp_valid && (inflight.size() > 0);
        if (exp_pop) head = inflight[0];

        check("m_req_valid", m_req_valid, exp_mvalid);
        check("i_req_ready", i_req_ready, exp_acc && !sel);
        check("d_req_ready", d_req_ready, exp_acc && sel);
        if (exp_mvalid) begin
            check("m_req_addr",  m_req_addr,  sel ? d_req_addr  : i_req_addr);
            check("m_req_we",    m_req_we,    sel ? d_req_we    : 1'b0);
            check("m_req_wdata", m_req_wdata, sel ? d_req_wdata : '0);
            check("m_req_wstrb", m_req_wstrb, sel ? d_req_wstrb : '0);
        end
        check("i_resp_valid", i_resp_valid, exp_pop && !head.side);
        check("d_resp_valid", d_resp_valid, exp_pop && head.side);
        if (exp_pop && !head.we) begin
            check("resp_data", head.side ? d_resp_data : i_resp_data, m_resp_data);
        end
`ifdef LADYBIRD_ARB_PERF_EN
        if (!reset) begin
            check("perf_i_grants",     perf_i_grants,     perf_i);
            check("perf_d_grants",     perf_d_grants,     perf_d);
            check("perf_stall_cycles", perf_stall_cycles, perf_stall);
        end
`endif
        snap_m_valid = m_req_valid;  snap_m_we    = m_req_we;
        snap_i_ready = i_req_ready;  snap_d_ready = d_req_ready;
        snap_i_resp  = i_resp_valid; snap_d_resp  = d_resp_valid;
        snap_m_addr  = m_req_addr;   snap_m_wdata = m_req_wdata;
        snap_m_wstrb = m_req_wstrb;

        @(posedge clk);
        last_i_acc = 1'b0;
        last_d_acc = 1'b0;
        if (reset) begin
            inflight.delete();
            mem_q.delete();
            held = 0; held_side = 0; fav_side = 0;
            perf_i = 0; perf_d = 0; perf_stall = 0;
        end else begin
            if (m_resp_valid && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                if (mem_budget > 0) mem_budget--;
            end
            if (exp_pop) void'(inflight.pop_front());
            if (exp_acc) begin
                inflight.push_back('{side: sel, we: sel ? d_req_we : 1'b0});
                mem_q.push_back('{due: cyc + $urandom_range(mem_lat_min, mem_lat_max),
                                  data: $urandom});
                fav_side = !sel;
                held     = 0;
                grant_log.push_back(sel);
                if (sel) perf_d++; else perf_i++;
                last_i_acc = !sel;
                last_d_acc = sel;
            end else if (exp_mvalid) begin
                held      = 1;
                held_side = sel;
            end
            if ((i_req_valid || d_req_valid) && !exp_acc) perf_stall++;
        end
        cyc++;
        #1;
    endtask

    // Let pending requests finish and all responses return.
    task automatic drain();
        m_req_ready = 1'b1;
        mem_budget  = -1;
        spurious_en = 0;
        for (int c = 0; c < 40; c++) begin
            if (last_i_acc) i_req_valid = 1'b0;
            if (last_d_acc) d_req_valid = 1'b0;
            if (!i_req_valid && !d_req_valid && mem_q.size() == 0) break;
            drive_mem();
            step();
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        last_i_acc  = 1'b0;
        last_d_acc  = 1'b0;
    endtask

    // Random requesters: keep a request stable until it is accepted.
    task automatic drive_reqs();
        if (!i_req_valid || last_i_acc) begin
            i_req_valid = ($urandom_range(0, 2) != 0);
            i_req_addr  = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req_valid || last_d_acc) begin
            d_req_valid = ($urandom_range(0, 2) != 0);
            d_req_addr  = $urandom & 32'hFFFF_FFFC;
            d_req_we    = $urandom_range(0, 1);
            d_req_wdata = $urandom;
            d_req_wstrb = STRB_W'($urandom);
        end
        last_i_acc = 1'b0;
        last_d_acc = 1'b0;
    endtask

    // Watchdog: the run is bounded by loops, this only guards against a stuck simulator.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rst_left;
        reset        = 1'b1;
        i_req_valid  = 1'b1;  i_req_addr  = 32'h0000_1000;
        d_req_valid  = 1'b1;  d_req_addr  = 32'h0000_8000;
        d_req_we     = 1'b0;  d_req_wdata = '0;  d_req_wstrb = '0;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b0;  m_resp_data = '0;
        held = 0; held_side = 0; fav_side = 0;
        perf_i = 0; perf_d = 0; perf_stall = 0;
        last_i_acc = 0; last_d_acc = 0;

        // ---- 1: reset held 3 cycles with every valid high ----
        repeat (3) begin
            drive_mem();
            step();
        end
        check("t1 m_req_valid in reset", snap_m_valid, 1'b0);
        check("t1 i_req_ready in reset", snap_i_ready, 1'b0);
        check("t1 d_req_ready in reset", snap_d_ready, 1'b0);
        reset = 1'b0;
        grant_log.delete();

        // ---- 2: continuous contention, 1-cycle memory ----
        for (int k = 0; k < 10; k++) begin
            drive_mem();
            step();
            if (last_i_acc) begin i_req_addr = i_req_addr + 32'd4; last_i_acc = 0; end
            if (last_d_acc) begin d_req_addr = d_req_addr + 32'd4; last_d_acc = 0; end
        end
        check("t2 grant count", grant_log.size(), 10);
        for (int k = 0; k < grant_log.size() && k < 10; k++) begin
            check($sformatf("t2 grant %0d side", k), grant_log[k], k % 2);
        end
`ifdef LADYBIRD_ARB_PERF_EN
        check("t6 perf_i_grants", perf_i_grants, 32'd5);
        check("t6 perf_d_grants", perf_d_grants, 32'd5);
`endif
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        drain();

        // ---- 3: lock holds D while memory stalls ----
        grant_log.delete();
        d_req_valid = 1'b1; d_req_addr = 32'h0000_D000; d_req_we = 1'b0;
        m_req_ready = 1'b0;
        drive_mem();
        step();
        check("t3 lock addr c1", snap_m_addr, 32'h0000_D000);
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1000;
        for (int c = 2; c <= 4; c++) begin
            drive_mem();
            step();
            check($sformatf("t3 lock addr c%0d", c), snap_m_addr, 32'h0000_D000);
            check($sformatf("t3 m_req_valid c%0d", c), snap_m_valid, 1'b1);
        end
        m_req_ready = 1'b1;
        drive_mem();
        step();
        check("t3 d accepted c5", snap_d_ready, 1'b1);
        d_req_valid = 1'b0;
        last_d_acc  = 1'b0;
        drive_mem();
        step();
        check("t3 i accepted c6", snap_i_ready, 1'b1);
        check("t3 grant count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t3 first grant", grant_log[0], 1'b1);
            check("t3 second grant", grant_log[1], 1'b0);
        end
        drain();

        // ---- 4: FIFO full, memory withholds responses ----
        grant_log.delete();
        mem_budget  = 0;
        i_req_valid = 1'b1; i_req_addr = 32'h0000_2000;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_9000; d_req_we = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 6; c++) begin
                drive_mem();
                step();
                if (last_i_acc) begin i_req_addr = i_req_addr + 32'd4; last_i_acc = 0; end
                if (last_d_acc) begin d_req_addr = d_req_addr + 32'd4; last_d_acc = 0; end
            end
            check($sformatf("t4 accepts pass%0d", pass), grant_log.size(), pass + 2);
            check($sformatf("t4 m_req_valid when full pass%0d", pass), snap_m_valid, 1'b0);
            mem_budget = 1;
        end
        drain();

        // ---- 5: store forwarding and ack routing ----
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h0000_0040;
        d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'b0011;
        drive_mem();
        step();
        check("t5 m_req_valid", snap_m_valid, 1'b1);
        check("t5 m_req_we",    snap_m_we,    1'b1);
        check("t5 m_req_addr",  snap_m_addr,  32'h0000_0040);
        check("t5 m_req_wdata", snap_m_wdata, 32'hDEAD_BEEF);
        check("t5 m_req_wstrb", snap_m_wstrb, 4'b0011);
        d_req_valid = 1'b0; d_req_we = 1'b0;
        last_d_acc  = 1'b0;
        drive_mem();
        step();
        check("t5 d_resp_valid", snap_d_resp, 1'b1);
        check("t5 i_resp_valid", snap_i_resp, 1'b0);
        drain();

        // ---- random traffic with stalls, latency, stale responses and resets ----
        spurious_en = 1;
        mem_lat_min = 1;
        mem_lat_max = 4;
        rst_left    = 0;
        for (int c = 0; c < 4000; c++) begin
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 299) == 0) rst_left = 2;
            end
            m_req_ready = ($urandom_range(0, 3) != 0);
            drive_reqs();
            drive_mem();
            step();
        end
        reset = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
